// File: rtl/fma16_result_stage.sv
// Registered 2-entry elastic output stage for the half-precision FMA, with sticky fflags.
// Optional build macro FMA16_NAN_CANON_EN: store every NaN result as canonical quiet NaN 16'h7E00.
module fma16_result_stage #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_result,
  input  logic [3:0]  in_flags,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_result,
  output logic [3:0]  out_flags,
  output logic [3:0]  fflags,
  input  logic        fflags_clr,
  output logic [1:0]  occupancy
);

  if (DEPTH != 2) begin : g_depth_check
    $error("fma16_result_stage: only DEPTH == 2 is supported");
  end

  logic [19:0] entry_p1 [2];
  logic        wp;
  logic        rp;
  logic [1:0]  count;
  logic        push;
  logic        pop;

  function automatic logic [15:0] nan_canon(input logic [15:0] r);
`ifdef FMA16_NAN_CANON_EN
    if ((r[14:10] == 5'h1F) && (r[9:0] != 10'h000)) return 16'h7E00;
    return r;
`else
    return r;
`endif
  endfunction

  // Ready/valid depend on the registered count only, so neither side sees a combinational path.
  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign occupancy = count;

  assign out_result = entry_p1[rp][19:4];
  assign out_flags  = entry_p1[rp][3:0];

  // Stage boundary: FMA result captured into the buffer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      entry_p1[0] <= '0;
      entry_p1[1] <= '0;
      wp          <= 1'b0;
      rp          <= 1'b0;
      count       <= 2'd0;
      fflags      <= 4'h0;
    end else begin
      if (push) begin
        entry_p1[wp] <= {nan_canon(in_result), in_flags};
        wp           <= ~wp;
      end
      if (pop) rp <= ~rp;
      if (push && !pop)      count <= count + 2'd1;
      else if (pop && !push) count <= count - 2'd1;
      // A flag arriving with the clear is kept.
      fflags <= (fflags_clr ? 4'h0 : fflags) | (push ? in_flags : 4'h0);
    end
  end

endmodule

// File: tb/tb_fma16_result_stage.sv
// Bench for fma16_result_stage: queue-based reference model plus directed literal checks.
module tb_fma16_result_stage;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_result;
  logic [3:0]  in_flags;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic [3:0]  out_flags;
  logic [3:0]  fflags;
  logic        fflags_clr;
  logic [1:0]  occupancy;

  int n_vec = 0;
  int n_err = 0;

  fma16_result_stage #(.DEPTH(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_flags(in_flags),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags),
    .fflags(fflags), .fflags_clr(fflags_clr), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

`ifdef FMA16_NAN_CANON_EN
  localparam bit CANON = 1'b1;
`else
  localparam bit CANON = 1'b0;
`endif

  function automatic logic [15:0] stored_value(input logic [15:0] r);
    if (CANON && (r[14:10] == 5'h1F) && (r[9:0] != 0)) return 16'h7E00;
    return r;
  endfunction

  // Reference model: a bounded FIFO of {result, flags} and a sticky flag word.
  logic [19:0] mq[$];
  logic [3:0]  m_ff;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      m_ff = 4'h0;
    end else begin
      bit do_push, do_pop;
      do_push = in_valid && (mq.size() < 2);
      do_pop  = (mq.size() > 0) && out_ready;
      m_ff = (fflags_clr ? 4'h0 : m_ff) | (do_push ? in_flags : 4'h0);
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back({stored_value(in_result), in_flags});
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("m_out_valid", 32'(out_valid), 32'(mq.size() != 0));
    chk("m_in_ready", 32'(in_ready), 32'(mq.size() != 2));
    chk("m_occupancy", 32'(occupancy), 32'(mq.size()));
    chk("m_fflags", 32'(fflags), 32'(m_ff));
    if (mq.size() != 0) begin
      chk("m_out_result", 32'(out_result), 32'(mq[0][19:4]));
      chk("m_out_flags", 32'(out_flags), 32'(mq[0][3:0]));
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_result = '0; in_flags = '0;
    out_ready = 1'b0; fflags_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_fflags", 32'(fflags), 0);
    chk("rst_occupancy", 32'(occupancy), 0);
    chk("rst_out_result", 32'(out_result), 0);
    chk("rst_out_flags", 32'(out_flags), 0);

    // First push, one cycle latency
    in_valid = 1'b1; in_result = 16'h3C00; in_flags = 4'b0001;
    cycle();
    in_valid = 1'b0;
    chk("first_valid", 32'(out_valid), 1);
    chk("first_result", 32'(out_result), 32'h3C00);
    chk("first_flags", 32'(out_flags), 32'b0001);
    chk("first_fflags", 32'(fflags), 32'b0001);
    out_ready = 1'b1;
    cycle();
    chk("first_drained", 32'(occupancy), 0);
    out_ready = 1'b0;

    // Backpressure: third offer must wait
    in_valid = 1'b1; in_flags = 4'h0; in_result = 16'h4000;
    cycle();
    in_result = 16'h4200;
    cycle();
    in_result = 16'h4400;
    cycle();
    chk("full_in_ready", 32'(in_ready), 0);
    chk("full_occupancy", 32'(occupancy), 2);
    chk("full_head", 32'(out_result), 32'h4000);
    out_ready = 1'b1;
    cycle();
    chk("bp_pop1", 32'(out_result), 32'h4200);
    chk("bp_ready_back", 32'(in_ready), 1);
    chk("bp_occ1", 32'(occupancy), 1);
    cycle();
    in_valid = 1'b0;
    chk("bp_pop3", 32'(out_result), 32'h4400);
    chk("bp_occ2", 32'(occupancy), 1);
    cycle();
    chk("bp_empty", 32'(occupancy), 0);

    // Streaming with wrap
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_result = 16'(i); in_flags = 4'h0;
      cycle();
      chk("stream_result", 32'(out_result), 32'(i));
      chk("stream_occ", 32'(occupancy), 1);
    end
    in_valid = 1'b0;
    cycle();
    chk("stream_empty", 32'(out_valid), 0);

    // Sticky flags and clear collision
    fflags_clr = 1'b1;
    cycle();
    fflags_clr = 1'b0;
    chk("clr_fflags", 32'(fflags), 0);
    in_valid = 1'b1; in_result = 16'h3800; in_flags = 4'b0100;
    cycle();
    chk("sticky_fflags", 32'(fflags), 32'b0100);
    fflags_clr = 1'b1; in_flags = 4'b1000;
    cycle();
    fflags_clr = 1'b0; in_valid = 1'b0;
    chk("clr_push_fflags", 32'(fflags), 32'b1000);
    cycle();

    // NaN handling and infinity passthrough
    in_valid = 1'b1; in_result = 16'hFC01; in_flags = 4'b1000;
    cycle();
    chk("nan_result", 32'(out_result), CANON ? 32'h7E00 : 32'hFC01);
    chk("nan_flags", 32'(out_flags), 32'b1000);
    in_result = 16'h7C00; in_flags = 4'b0000;
    cycle();
    in_valid = 1'b0;
    chk("inf_result", 32'(out_result), 32'h7C00);
    cycle();

    // Fill, then asynchronous reset mid-cycle
    fflags_clr = 1'b1;
    cycle();
    fflags_clr = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; in_result = 16'h1111; in_flags = 4'b0001;
    cycle();
    in_result = 16'h2222; in_flags = 4'b0010;
    cycle();
    in_valid = 1'b0;
    chk("pre_rst_occ", 32'(occupancy), 2);
    chk("pre_rst_fflags", 32'(fflags), 32'b0011);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_fflags", 32'(fflags), 0);
    chk("arst_in_ready", 32'(in_ready), 1);
    chk("arst_occ", 32'(occupancy), 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    in_valid = 1'b1; in_result = 16'h1234; in_flags = 4'h0;
    cycle();
    in_valid = 1'b0;
    chk("post_rst_result", 32'(out_result), 32'h1234);
    chk("post_rst_occ", 32'(occupancy), 1);
    out_ready = 1'b1;
    cycle();
    chk("post_rst_empty", 32'(occupancy), 0);
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
